// File: rtl/game_pkg.sv
// Shared game constants and types.
// Used by the judge stage, the lane blocks and the renderer so that
// lane count, y-position width and hit-window bounds stay consistent.
// Also holds the addscore FSM state type and a lane popcount helper.
package game_pkg;

  localparam int NUM_LANES = 4;
  localparam int YPOS_W    = 7;
  localparam int HIT_LO    = 100;
  localparam int HIT_HI    = 115;
  localparam int COMBO_W   = 8;
  localparam int PEND_W    = 3;

  // Wide enough to hold the number of hits judged in a single cycle.
  localparam int HITCNT_W  = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pulse_state_t;

  function automatic logic [HITCNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [HITCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt = cnt + HITCNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Bus between the lane blocks / score block and the hit judge.
//   key        : player keys, level, already synchronised
//   note_valid : lane has a live note
//   note_y     : packed per-lane y positions, lane i at [i*YPOS_W +: YPOS_W]
//   note_clear : one-cycle despawn request per lane
//   addscore   : one-cycle score pulse per hit, always separated by a low cycle
//   miss       : one-cycle pulse when any miss is judged
//   combo      : consecutive hits since the last miss
// master = lane/score side, slave = judge.
interface hit_judge_if
  import game_pkg::*;
  ;

  logic [NUM_LANES-1:0]        key;
  logic [NUM_LANES-1:0]        note_valid;
  logic [NUM_LANES*YPOS_W-1:0] note_y;
  logic [NUM_LANES-1:0]        note_clear;
  logic                        addscore;
  logic                        miss;
  logic [COMBO_W-1:0]          combo;

  modport master (
    output key, note_valid, note_y,
    input  note_clear, addscore, miss, combo
  );

  modport slave (
    input  key, note_valid, note_y,
    output note_clear, addscore, miss, combo
  );

endinterface

// File: rtl/score_pulser.sv
// Turns a per-cycle hit count into separated addscore pulses.
// The downstream score block counts rising edges, so every pulse is
// followed by at least one low cycle. Hits beyond what the pending
// counter can hold are dropped.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   hit_cnt    : number of hits judged this cycle
//   addscore   : high while in PULSE
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | nothing pending, addscore low
// PULSE | addscore high for one cycle, one pending hit consumed
// GAP   | mandatory low cycle before the next pulse
module score_pulser
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [HITCNT_W-1:0] hit_cnt,
  output logic                addscore
);

  localparam int SUM_W = ((PEND_W > HITCNT_W) ? PEND_W : HITCNT_W) + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

  pulse_state_t      state, state_nxt;
  logic [PEND_W-1:0] pending, pending_nxt;
  logic [SUM_W-1:0]  pend_sum;
  logic              consume;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending != '0) state_nxt = PULSE;
      PULSE:   state_nxt = GAP;
      GAP:     state_nxt = (pending != '0) ? PULSE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A hit is consumed on entry to PULSE; new hits land on the same edge.
  always_comb begin
    consume     = (state_nxt == PULSE) && (state != PULSE);
    pend_sum    = SUM_W'(pending) + SUM_W'(hit_cnt) - SUM_W'(consume);
    pending_nxt = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
  end

  assign addscore = (state == PULSE);

endmodule

// File: rtl/hit_judge.sv
// Rhythm-game judge stage. Compares key presses against falling-note
// positions per lane, decides hit or miss, requests note despawn,
// tracks combo and feeds hits to score_pulser for addscore pulses.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : hit_judge_if slave (keys and lane state in, judgement out)
module hit_judge
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  hit_judge_if.slave bus
);

  localparam logic [YPOS_W-1:0]  Y_LO      = YPOS_W'(HIT_LO);
  localparam logic [YPOS_W-1:0]  Y_HI      = YPOS_W'(HIT_HI);
  localparam logic [COMBO_W:0]   COMBO_MAX = {1'b0, {COMBO_W{1'b1}}};

  logic [NUM_LANES-1:0] key_q;
  logic [NUM_LANES-1:0] armed, armed_nxt;
  logic [NUM_LANES-1:0] press, hit, pass, bad_press, clear_nxt;
  logic [NUM_LANES-1:0] note_clear_r;
  logic                 miss_r, miss_nxt;
  logic [COMBO_W-1:0]   combo_r, combo_nxt;
  logic [COMBO_W:0]     combo_sum;
  logic [HITCNT_W-1:0]  hit_cnt;
  logic [YPOS_W-1:0]    y;
  logic                 addscore;

  always_comb begin
    press     = bus.key & ~key_q;
    hit       = '0;
    pass      = '0;
    bad_press = '0;
    y         = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      y            = bus.note_y[i*YPOS_W +: YPOS_W];
      hit[i]       = press[i] & armed[i] & bus.note_valid[i] & (y >= Y_LO) & (y <= Y_HI);
      pass[i]      = armed[i] & bus.note_valid[i] & (y > Y_HI);
      // A press that coincides with a pass lands here too; miss is one
      // wire so the lane still produces a single miss.
      bad_press[i] = press[i] & ~hit[i];
    end
    clear_nxt = hit | pass;
    miss_nxt  = |(bad_press | pass);
    hit_cnt   = popcount(hit);
    // Disarm on the same edge that issues note_clear so the note cannot
    // be judged again while the lane is still despawning it.
    armed_nxt = ~bus.note_valid | (armed & ~clear_nxt);
  end

  always_comb begin
    combo_sum = {1'b0, combo_r} + (COMBO_W+1)'(hit_cnt);
    if (miss_nxt)
      combo_nxt = '0;
    else if (combo_sum > COMBO_MAX)
      combo_nxt = COMBO_MAX[COMBO_W-1:0];
    else
      combo_nxt = combo_sum[COMBO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q        <= '0;
      armed        <= '1;
      note_clear_r <= '0;
      miss_r       <= 1'b0;
      combo_r      <= '0;
    end else begin
      key_q        <= bus.key;
      armed        <= armed_nxt;
      note_clear_r <= clear_nxt;
      miss_r       <= miss_nxt;
      combo_r      <= combo_nxt;
    end
  end

  score_pulser u_score_pulser (
    .clk      (clk),
    .reset    (reset),
    .hit_cnt  (hit_cnt),
    .addscore (addscore)
  );

  assign bus.note_clear = note_clear_r;
  assign bus.miss       = miss_r;
  assign bus.combo      = combo_r;
  assign bus.addscore   = addscore;

endmodule
